packed_isqrt: RTL and testbench

- Inverse of the existing packed squarer: takes 8 packed 16-bit unsigned values and returns 8 packed 8-bit integer square roots, floor(sqrt(x)).
- Each lane also returns a per-lane "exact" flag, set when the input was a perfect square.
- Iterative, bit-serial: one root bit per cycle, all lanes in parallel, no multipliers.
- Sits downstream of squarer-produced data; valid/ready on both sides.

---
 rtl/isqrt_pkg.sv | 17 +
 rtl/isqrt_lane.sv | 53 +++++
 rtl/packed_isqrt.sv | 102 ++++++++++
 tb/tb_packed_isqrt.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isqrt_pkg.sv
// Shared constants and state encoding for the packed integer square-root block.
package isqrt_pkg;

  localparam int LANES = 8;
  localparam int IN_W  = 16;
  localparam int OUT_W = IN_W / 2;
  // Remainder is bounded by 2*root, two spare bits keep the 0xFFFF case safe.
  localparam int REM_W = OUT_W + 2;
  localparam int CNT_W = $clog2(OUT_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/isqrt_lane.sv
// One lane of the restoring square root: resolves one root bit per step, MSB first.
// root/exact present the value the lane will hold after the current step.
module isqrt_lane
  import isqrt_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [IN_W-1:0]  radicand,
  output logic [OUT_W-1:0] root,
  output logic             exact
);

  logic [IN_W-1:0]  rad_reg;
  logic [REM_W-1:0] rem_reg;
  logic [OUT_W-1:0] root_reg;

  logic [REM_W+1:0] rem_shift;
  logic [REM_W+1:0] trial;
  logic [REM_W-1:0] rem_sub;
  logic [REM_W-1:0] rem_next;
  logic [OUT_W-1:0] root_next;
  logic             bit_set;

  // Bring down the next radicand bit pair and try subtracting 4*root+1.
  assign rem_shift = {rem_reg, rad_reg[IN_W-1 -: 2]};
  assign trial     = {2'b00, root_reg, 2'b01};
  assign bit_set   = (rem_shift >= trial);
  assign rem_sub   = rem_shift[REM_W-1:0] - trial[REM_W-1:0];
  assign rem_next  = bit_set ? rem_sub : rem_shift[REM_W-1:0];
  assign root_next = {root_reg[OUT_W-2:0], bit_set};

  assign root  = root_next;
  assign exact = (rem_next == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rad_reg  <= '0;
      rem_reg  <= '0;
      root_reg <= '0;
    end else if (load) begin
      rad_reg  <= radicand;
      rem_reg  <= '0;
      root_reg <= '0;
    end else if (step) begin
      rad_reg  <= {rad_reg[IN_W-3:0], 2'b00};
      rem_reg  <= rem_next;
      root_reg <= root_next;
    end
  end

endmodule

// File: rtl/packed_isqrt.sv
// Packed 8-lane floor(sqrt) of 16-bit values with per-lane perfect-square flags.
// Bit-serial over OUT_W cycles, valid/ready handshake on both sides.
module packed_isqrt
  import isqrt_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*IN_W-1:0]  data_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] data_out,
  output logic [LANES-1:0]       exact
);

  state_t state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg;
  logic [LANES*OUT_W-1:0] data_out_reg;
  logic [LANES-1:0]       exact_reg;

  logic [LANES*OUT_W-1:0] root_all;
  logic [LANES-1:0]       exact_all;
  logic                   accept;
  logic                   step;
  logic                   last_step;

  assign accept    = in_valid && in_ready;
  assign step      = (state_reg == CALC);
  assign last_step = step && (cnt_reg == '0);

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      isqrt_lane u_lane (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .step     (step),
        .radicand (data_in[gi*IN_W +: IN_W]),
        .root     (root_all[gi*OUT_W +: OUT_W]),
        .exact    (exact_all[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = CALC;
      CALC: if (cnt_reg == '0) state_next = DONE;
      DONE: if (out_ready) state_next = in_valid ? CALC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // in_ready is forced low while reset is held so nothing is accepted into a dying pipe.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_reg)
      IDLE: in_ready = rst_n;
      DONE: begin
        in_ready  = rst_n && out_ready;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg      <= '0;
      data_out_reg <= '0;
      exact_reg    <= '0;
    end else begin
      if (accept) begin
        cnt_reg <= CNT_W'(OUT_W - 1);
      end else if (step && cnt_reg != '0) begin
        cnt_reg <= cnt_reg - CNT_W'(1);
      end
      if (last_step) begin
        data_out_reg <= root_all;
        exact_reg    <= exact_all;
      end
    end
  end

  assign data_out = data_out_reg;
  assign exact    = exact_reg;

endmodule

// File: tb/tb_packed_isqrt.sv
// Self-checking bench for packed_isqrt: vector table, scoreboard queue, corner sequences.
module tb_packed_isqrt;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  data_out;
  logic [7:0]   exact;

  always #5 clk = ~clk;

  packed_isqrt dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .exact     (exact)
  );

  typedef struct {
    logic [127:0] din;
    logic [63:0]  root;
    logic [7:0]   exact;
  } vec_t;

  typedef struct {
    logic [63:0] root;
    logic [7:0]  exact;
  } exp_t;

  exp_t sb[$];
  vec_t tv[4];
  int   n_pass = 0;
  int   n_total = 0;
  time  last_accept = 0;
  time  prev_accept = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  function automatic int isqrt_model(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // Scoreboard monitor: a result is consumed when out_valid && out_ready at the next edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("result root=%h exact=%h expect root=%h exact=%h", data_out, exact, e.root, e.exact);
        check("root", data_out, e.root);
        check("exact", {56'd0, exact}, {56'd0, e.exact});
      end
    end
  end

  task automatic send(input logic [127:0] d, input logic [63:0] r, input logic [7:0] e);
    int   t;
    exp_t x;
    in_valid = 1'b1;
    data_in  = d;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("accept_timeout", 64'd0, 64'd1);
    end else begin
      x.root  = r;
      x.exact = e;
      sb.push_back(x);
      prev_accept = last_accept;
      last_accept = $time;
      $display("accept din=%h", d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_model(input logic [127:0] d);
    logic [63:0] r;
    logic [7:0]  e;
    int v, q;
    for (int k = 0; k < 8; k++) begin
      v = int'(d[k*16 +: 16]);
      q = isqrt_model(v);
      r[k*8 +: 8] = q[7:0];
      e[k] = (q * q == v);
    end
    send(d, r, e);
  endtask

  task automatic drain();
    int t = 0;
    in_valid = 1'b0;
    while (sb.size() != 0 && t < 200) begin
      t++;
      @(posedge clk);
      #1;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic wait_out_valid();
    int t = 0;
    @(negedge clk);
    while (!out_valid && t < 50) begin
      t++;
      @(negedge clk);
    end
    check("out_valid_timeout", {63'd0, out_valid}, 64'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int hits;
    int vals[$];
    logic [63:0]  rr;
    logic [127:0] dd;

    tv[0].din   = {16'd65025, 16'd65535, 16'd0, 16'd1, 16'd2, 16'd144, 16'd255, 16'd256};
    tv[0].root  = {8'd255, 8'd255, 8'd0, 8'd1, 8'd1, 8'd12, 8'd15, 8'd16};
    tv[0].exact = 8'b1011_0101;
    tv[1].din   = {8{16'd100}};
    tv[1].root  = {8{8'd10}};
    tv[1].exact = 8'hFF;
    tv[2].din   = {16'd3, 16'd4, 16'd8, 16'd9, 16'd15, 16'd16, 16'd24, 16'd25};
    tv[2].root  = {8'd1, 8'd2, 8'd2, 8'd3, 8'd3, 8'd4, 8'd4, 8'd5};
    tv[2].exact = 8'h55;
    tv[3].din   = {16'd65024, 16'd64516, 16'd64515, 16'd10000, 16'd9999, 16'd48, 16'd49, 16'd50};
    tv[3].root  = {8'd254, 8'd254, 8'd253, 8'd100, 8'd99, 8'd6, 8'd7, 8'd7};
    tv[3].exact = 8'h52;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; data_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_data_out", data_out, 64'd0);
    check("rst_exact", {56'd0, exact}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;

    // Single vector with latency measurement.
    send(tv[0].din, tv[0].root, tv[0].exact);
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
    check("latency", 64'(lat), 64'd9);
    @(posedge clk); #1;
    drain();

    // Table, back-to-back with in_valid and out_ready held high.
    for (int i = 0; i < 4; i++) begin
      send(tv[i].din, tv[i].root, tv[i].exact);
      if (i > 0) check("b2b_interval", 64'(last_accept - prev_accept), 64'd90);
    end
    drain();

    // Backpressure: result held in DONE while new input waits.
    out_ready = 1'b0;
    send(tv[2].din, tv[2].root, tv[2].exact);
    data_in = {$urandom, $urandom, $urandom, $urandom};
    wait_out_valid();
    for (int i = 0; i < 5; i++) begin
      check("bp_data_out", data_out, tv[2].root);
      check("bp_exact", {56'd0, exact}, {56'd0, tv[2].exact});
      check("bp_in_ready", {63'd0, in_ready}, 64'd0);
      @(posedge clk); #1;
      data_in = (i == 4) ? tv[3].din : {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
    begin
      exp_t x;
      x.root = tv[3].root;
      x.exact = tv[3].exact;
      sb.push_back(x);
    end
    @(posedge clk); #1;
    drain();

    // Reset while a result is held in DONE.
    out_ready = 1'b0;
    send(tv[0].din, tv[0].root, tv[0].exact);
    in_valid = 1'b0;
    wait_out_valid();
    @(posedge clk); #1;
    rst_n = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("done_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("done_rst_data_out", data_out, 64'd0);
    check("done_rst_exact", {56'd0, exact}, 64'd0);
    check("done_rst_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("done_rst_release_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;

    // Reset during CALC: no result may appear afterwards.
    send(tv[3].din, tv[3].root, tv[3].exact);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    hits = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) hits++;
    end
    check("calc_rst_no_result", 64'(hits), 64'd0);
    @(posedge clk); #1;
    send(tv[1].din, tv[1].root, tv[1].exact);
    drain();

    // Round trip: square random roots, expect the roots back with exact set.
    for (int i = 0; i < 1000; i++) begin
      rr = {$urandom, $urandom};
      for (int k = 0; k < 8; k++) begin
        dd[k*16 +: 16] = 16'(rr[k*8 +: 8]) * 16'(rr[k*8 +: 8]);
      end
      send(dd, rr, 8'hFF);
    end
    drain();

    // Sweep every perfect-square boundary plus the top value against the model.
    for (int r = 0; r < 256; r++) begin
      if (r > 0) vals.push_back(r * r - 1);
      vals.push_back(r * r);
      vals.push_back(r * r + 1);
    end
    vals.push_back(65535);
    while (vals.size() % 8 != 0) vals.push_back(0);
    for (int i = 0; i < vals.size(); i += 8) begin
      for (int k = 0; k < 8; k++) dd[k*16 +: 16] = vals[i+k][15:0];
      send_model(dd);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
